// File: rtl/modexp_pkg.sv
// Shared definitions for the modexp_param slice: FSM encoding, default widths and
// the iteration count of the interleaved modular multiplier.
package modexp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StScan,
        StSqr,
        StMul,
        StDone
    } state_t;

    localparam int unsigned DefaultW  = 64;
    localparam int unsigned DefaultEW = DefaultW;

    // One multiplier bit is consumed per iteration.
    function automatic int unsigned modmul_iters(input int unsigned w);
        return w;
    endfunction

    // Load cycle plus iterations.
    function automatic int unsigned modmul_cycles(input int unsigned w);
        return modmul_iters(w) + 1;
    endfunction

endpackage

// File: rtl/modmul_blakley.sv
// Blakley interleaved modular multiplier: p = a*b mod n, MSB-first over a, one bit per
// cycle. done and p are presented combinationally during the final iteration.
module modmul_blakley
    import modexp_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] p,
    output logic         done
);
    localparam int unsigned CW = $clog2(W);

    logic [W+1:0]  r_q, t0, t1, t2, n_ext;
    logic [W-1:0]  a_q, b_q, n_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    // r < n on entry, so 2r + b < 3n and two subtractions always suffice.
    always_comb begin
        n_ext = {2'b00, n_q};
        t0    = (r_q << 1) + {2'b00, b_q & {W{a_q[W-1]}}};
        t1    = (t0 >= n_ext) ? t0 - n_ext : t0;
        t2    = (t1 >= n_ext) ? t1 - n_ext : t1;
    end

    assign p    = t2[W-1:0];
    assign done = run_q && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            r_q   <= '0;
            a_q   <= a;
            b_q   <= b;
            n_q   <= n;
            cnt_q <= CW'(modmul_iters(W) - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            r_q <= t2;
            a_q <= a_q << 1;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/modexp_param.sv
// Left-to-right square-and-multiply modular exponentiation over a shared Blakley multiplier.
// Define MODEXP_SCAN_EN to skip leading zero exponent bits without squaring.
module modexp_param
    import modexp_pkg::*;
#(
    parameter int unsigned W  = DefaultW,
    parameter int unsigned EW = W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp,
    input  logic [W-1:0]  modulus,
    output logic [W-1:0]  result,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int unsigned PW = (EW > 1) ? $clog2(EW) : 1;

    state_t        state_q, state_d;
    logic [W-1:0]  base_q, mod_q, acc_q, acc_d, result_q, result_d;
    logic [EW-1:0] exp_q;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d, op_act_q, op_act_d;
    logic          capture, mm_start, mm_done;
    logic [W-1:0]  mm_b, mm_p;

    modmul_blakley #(
        .W(W)
    ) u_modmul (
        .clk  (clk),
        .rst  (rst),
        .start(mm_start),
        .a    (acc_q),
        .b    (mm_b),
        .n    (mod_q),
        .p    (mm_p),
        .done (mm_done)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ptr_d    = ptr_q;
        result_d = result_q;
        err_d    = err_q;
        op_act_d = op_act_q;
        capture  = 1'b0;
        mm_start = 1'b0;
        mm_b     = acc_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture  = 1'b1;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (mod_q == '0 || base_q >= mod_q) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = StDone;
                end else begin
                    acc_d = (mod_q == W'(1)) ? '0 : W'(1);
                    ptr_d = PW'(EW - 1);
`ifdef MODEXP_SCAN_EN
                    state_d = exp_q[EW-1] ? StSqr : StScan;
`else
                    state_d = StSqr;
`endif
                end
            end
            StScan: begin
                // ptr_q marks the zero bit being skipped this cycle.
                if (ptr_q == '0) begin
                    result_d = acc_q;
                    state_d  = StDone;
                end else begin
                    ptr_d = ptr_q - PW'(1);
                    if (exp_q[ptr_d]) begin
                        state_d = StSqr;
                    end
                end
            end
            StSqr, StMul: begin
                if (state_q == StMul) begin
                    mm_b = base_q;
                end
                if (!op_act_q) begin
                    mm_start = 1'b1;
                    op_act_d = 1'b1;
                end
                if (mm_done) begin
                    op_act_d = 1'b0;
                    acc_d    = mm_p;
                    if (state_q == StSqr && exp_q[ptr_q]) begin
                        state_d = StMul;
                    end else if (ptr_q == '0) begin
                        result_d = mm_p;
                        state_d  = StDone;
                    end else begin
                        ptr_d   = ptr_q - PW'(1);
                        state_d = StSqr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            ptr_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            op_act_q <= 1'b0;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
            err_q    <= err_d;
            op_act_q <= op_act_d;
            if (capture) begin
                base_q <= base;
                exp_q  <= exp;
                mod_q  <= modulus;
            end
        end
    end

    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_modexp_param.sv
// Self-checking bench for modexp_param: a W=8 and a W=16 instance checked every cycle
// against a plain-arithmetic reference model.
module tb_modexp_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  b8 = '0, e8 = '0, n8 = '0, r8;
    logic [15:0] b16 = '0, e16 = '0, n16 = '0, r16;
    logic        busy8, done8, err8, busy16, done16, err16;

    modexp_param #(.W(8), .EW(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .base(b8), .exp(e8), .modulus(n8),
        .result(r8), .busy(busy8), .done(done8), .err(err8)
    );

    modexp_param #(.W(16), .EW(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .base(b16), .exp(e16), .modulus(n16),
        .result(r16), .busy(busy16), .done(done16), .err(err16)
    );

    logic [63:0] dres [2];
    logic        dbusy [2], ddone [2], derr [2];
    assign dres[0]  = {56'd0, r8};
    assign dres[1]  = {48'd0, r16};
    assign dbusy[0] = busy8;
    assign dbusy[1] = busy16;
    assign ddone[0] = done8;
    assign ddone[1] = done16;
    assign derr[0]  = err8;
    assign derr[1]  = err16;

    int checks = 0;
    int errors = 0;

    // Expected-behaviour state per instance.
    bit              act [2] = '{0, 0};
    int              cyc [2] = '{0, 0};
    int              lat [2] = '{0, 0};
    longint unsigned want_res [2] = '{0, 0};
    bit              want_err [2] = '{0, 0};
    longint unsigned held_res [2] = '{0, 0};
    bit              held_err [2] = '{0, 0};

    task automatic chk(input string name, input longint unsigned got,
                       input longint unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic longint unsigned ref_pow(input longint unsigned b, input longint unsigned e,
                                                input longint unsigned n);
        longint unsigned r;
        if (n == 0 || b >= n) return 0;
        r = 1 % n;
        for (longint unsigned i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    function automatic int ref_lat(input longint unsigned b, input longint unsigned e,
                                   input longint unsigned n, input int w, input int ew);
        int z;
        int pc;
        z  = 0;
        pc = $countones(e);
        if (n == 0 || b >= n) return 2;
`ifdef MODEXP_SCAN_EN
        for (int i = ew - 1; i >= 0 && e[i] == 1'b0; i--) z++;
`endif
        return 2 + z + (w + 1) * (ew - z + pc);
    endfunction

    // Compare process: every negedge, every instance.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (act[k]) begin
                    cyc[k]++;
                    chk($sformatf("busy_run%0d", k), dbusy[k], 1);
                    chk($sformatf("done_timing%0d_cyc%0d", k, cyc[k]), ddone[k],
                        (cyc[k] == lat[k]) ? 1 : 0);
                    if (cyc[k] == lat[k]) begin
                        chk($sformatf("result%0d", k), dres[k], want_res[k]);
                        chk($sformatf("err%0d", k), derr[k], want_err[k]);
                        held_res[k] = want_res[k];
                        held_err[k] = want_err[k];
                        act[k]      = 0;
                    end
                end else begin
                    chk($sformatf("busy_idle%0d", k), dbusy[k], 0);
                    chk($sformatf("done_idle%0d", k), ddone[k], 0);
                    chk($sformatf("result_held%0d", k), dres[k], held_res[k]);
                    chk($sformatf("err_held%0d", k), derr[k], held_err[k]);
                end
            end
        end
    end

    // Drives a request now; the accepting edge is the next posedge.
    task automatic launch(input int k, input longint unsigned b, input longint unsigned e,
                          input longint unsigned n);
        if (k == 0) begin
            b8 = b[7:0]; e8 = e[7:0]; n8 = n[7:0]; start8 = 1'b1;
        end else begin
            b16 = b[15:0]; e16 = e[15:0]; n16 = n[15:0]; start16 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8      = 1'b0;
        start16     = 1'b0;
        want_res[k] = ref_pow(b, e, n);
        want_err[k] = (n == 0 || b >= n);
        lat[k]      = ref_lat(b, e, n, (k == 0) ? 8 : 16, (k == 0) ? 8 : 16);
        cyc[k]      = 0;
        act[k]      = 1;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 3000 && act[k]; i++) @(negedge clk);
        checks++;
        if (act[k]) begin
            errors++;
            $display("FAIL timeout%0d got busy want done", k);
            act[k] = 0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int k, input longint unsigned b, input longint unsigned e,
                       input longint unsigned n);
        @(negedge clk);
        launch(k, b, e, n);
        wait_idle(k);
    endtask

    initial begin
        // Pin the reference model with hand-computed values.
        chk("model_4_13_97", ref_pow(4, 13, 97), 93);
        chk("model_65_17_3233", ref_pow(65, 17, 3233), 2790);
        chk("model_2790_413_3233", ref_pow(2790, 413, 3233), 65);
        chk("model_exp0", ref_pow(5, 0, 97), 1);
        chk("model_n1", ref_pow(0, 5, 1), 0);
        chk("model_lat_err", ref_lat(100, 3, 97, 8, 8), 2);
`ifdef MODEXP_SCAN_EN
        chk("model_lat_13", ref_lat(4, 13, 97, 8, 8), 69);
        chk("model_lat_exp0", ref_lat(5, 0, 97, 8, 8), 10);
`else
        chk("model_lat_13", ref_lat(4, 13, 97, 8, 8), 101);
        chk("model_lat_exp0", ref_lat(5, 0, 97, 8, 8), 74);
`endif

        repeat (3) @(negedge clk);
        chk("reset_result8", r8, 0);
        chk("reset_busy8", busy8, 0);
        chk("reset_done16", done16, 0);
        rst = 1'b0;

        // Main vector, with a start pulse while busy that must be ignored.
        @(negedge clk);
        launch(0, 4, 13, 97);
        repeat (20) @(negedge clk);
        b8 = 8'd1; e8 = 8'd1; n8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(0);
        chk("direct_93", r8, 93);

        run(0, 5, 0, 97);
        run(0, 0, 5, 1);
        run(0, 3, 5, 0);
        run(0, 100, 3, 97);
        chk("direct_err", err8, 1);
        run(0, 96, 255, 97);
        run(0, 4, 128, 97);

        // Abort midway, then start in the first cycle after release.
        @(negedge clk);
        launch(0, 4, 13, 97);
        repeat (40) @(negedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; held_res[k] = 0; held_err[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk("abort_result", r8, 0);
        rst = 1'b0;
        launch(0, 4, 13, 97);
        wait_idle(0);
        chk("rerun_93", r8, 93);

        run(1, 65, 17, 3233);
        chk("direct_2790", r16, 2790);
        run(1, 2790, 413, 3233);
        chk("direct_65", r16, 65);
        run(1, 65534, 3, 65535);
        run(1, 7, 1, 65535);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modexp_param.md
MODEXP_PARAM -- requirements
Module: modexp_param

Interface
REQ-001 Parameter W, 64, operand/modulus width in bits (W >= 4).
REQ-002 Parameter EW, W, exponent width in bits (EW >= 1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 base  input  W  base a; captured on accepted start.
REQ-007 exp  input  EW  exponent m; captured on accepted start.
REQ-008 modulus  input  W  modulus N; captured on accepted start.
REQ-009 result  output  W  a^m mod N; held until next accepted start.
REQ-010 busy  output  1  high from the cycle after accepted start until done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse; result/err valid in that cycle.
REQ-012 err  output  1  invalid-operand flag, valid with done.

Function
REQ-013 States: IDLE, LOAD, SCAN, SQR, MUL, DONE; encoding from shared package.
REQ-014 IDLE: start=1 captures base/exp/modulus and moves to LOAD; start while busy is ignored, no queueing.
REQ-015 LOAD: N==0 or base>=N sets err, result=0, goes to DONE; else acc=(N==1)?0:1, bit pointer=EW-1.
REQ-016 Algorithm: left-to-right square-and-multiply; per exponent bit: SQR acc=acc*acc mod N; if bit set, MUL acc=acc*base mod N; pointer decrements; after bit 0 go to DONE.
REQ-017 Each modular multiply uses modmul_blakley: interleaved shift-add, one multiplier bit per cycle, MSB first, R=2R+a_i*b then at most two conditional subtractions of N; internal R width W+2.
REQ-018 Each SQR or MUL occupies exactly W+1 cycles (1 load + W iterations); acc updated on the last.
REQ-019 DONE: done=1, result=acc (or 0 on err), busy=1; next cycle IDLE, busy=0.
REQ-020 Latency from start-accept edge to done: 2 + Z + (W+1)*(EW-Z+popcount(exp)), Z defined in REQ-027; err case: exactly 2.
REQ-021 exp==0: result = 1 mod N (0 when N==1); N==1: result 0 for all exp.
REQ-022 All arithmetic unsigned; operands strictly less than N for correctness; no truncation of intermediate values.

Reset
REQ-023 rst=1 asynchronously forces IDLE; result=0, busy=0, done=0, err=0; acc, pointer, captured operands cleared.
REQ-024 rst asserted mid-operation aborts with no done pulse; first start after release begins a fresh computation.
REQ-025 start sampled high in the first cycle after rst release is accepted normally.

Configuration
REQ-026 Macro MODEXP_SCAN_EN selects leading-zero skip.
REQ-027 Defined: LOAD enters SCAN, which consumes one cycle per leading zero exponent bit (Z = count of leading zeros, Z=EW when exp==0) without squaring, then SQR at the first set bit; undefined: SCAN unreachable, Z=0, all EW bits processed, latency data-independent except popcount.
REQ-028 Results identical with and without the macro.

Structure
REQ-029 Package modexp_pkg: state enum, default W/EW constants, modmul iteration-count function.
REQ-030 One sub-module modmul_blakley (parameter W; ports clk, rst, start, a, b, n, p, done), instantiated once and shared by SQR and MUL.
REQ-031 No hardware divider or full-width multiplier; all reduction via REQ-017.

Verification
REQ-032 W=8, EW=8: base=4, exp=13, N=97 -> result=93, err=0; done at cycle 2+9*(8+3)=101 without macro.
REQ-033 W=16, EW=16: base=65, exp=17, N=3233 -> 2790; then base=2790, exp=413, N=3233 -> 65.
REQ-034 W=8: exp=0, N=97 -> result=1; exp=5, N=1 -> result=0; N=0 or base=100, N=97 -> err=1, result=0, done 2 cycles after start.
REQ-035 Assert rst midway through REQ-032 run -> no done pulse, outputs zero; rerun -> 93; start pulses while busy ignored.
REQ-036 With MODEXP_SCAN_EN, W=8, EW=8, exp=13 (Z=4) -> result 93, done at 2+4+9*7=69; exp=0 -> result 1 at cycle 10.
